// File: rtl/ex_mc_ctrl_pkg.sv
// Shared definitions for the EX multi-cycle controller: state encodings,
// stall levels, stall-vector bit positions and bus widths.
package ex_mc_ctrl_pkg;

  localparam int STATE_W  = 2;
  localparam int DWORD_W  = 64;
  localparam int STALL_W  = 6;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  localparam logic [STATE_W-1:0] IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] MADD2    = 2'd1;
  localparam logic [STATE_W-1:0] DIV_BUSY = 2'd2;
  localparam logic [STATE_W-1:0] DIV_DONE = 2'd3;

  localparam logic        STOP      = 1'b1;
  localparam logic        NO_STOP   = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/ex_mc_ctrl_if.sv
// Bundle between the EX stage/pipeline controller (master) and the
// multi-cycle controller (slave); the divider signals pass through here too.
interface ex_mc_ctrl_if;
  import ex_mc_ctrl_pkg::*;

  logic [STALL_W-1:0] stall;
  logic               annul_i;
  logic               op_madd_i;
  logic               op_sub_i;
  logic [DWORD_W-1:0] mul_i;
  logic [DWORD_W-1:0] hilo_i;
  logic               op_div_i;
  logic               div_ready_i;
  logic [DWORD_W-1:0] div_result_i;
  logic               stallreq_o;
  logic               div_start_o;
  logic               div_annul_o;
  logic               madd_valid_o;
  logic [DWORD_W-1:0] madd_result_o;
  logic               div_valid_o;
  logic [DWORD_W-1:0] div_result_o;

  // Valid semantics: madd_valid_o/div_valid_o qualify their result in the
  // same cycle and stay asserted, with stable data, until stall[4] drops;
  // there is no ready back-pressure other than the stall vector.
  modport master (
    output stall, annul_i, op_madd_i, op_sub_i, mul_i, hilo_i,
           op_div_i, div_ready_i, div_result_i,
    input  stallreq_o, div_start_o, div_annul_o, madd_valid_o,
           madd_result_o, div_valid_o, div_result_o
  );

  modport slave (
    input  stall, annul_i, op_madd_i, op_sub_i, mul_i, hilo_i,
           op_div_i, div_ready_i, div_result_i,
    output stallreq_o, div_start_o, div_annul_o, madd_valid_o,
           madd_result_o, div_valid_o, div_result_o
  );

endinterface

// File: rtl/ex_mc_ctrl.sv
// EX-stage multi-cycle controller: two-cycle madd/msub accumulate and
// start/hold/abort sequencing for an external divider.
module ex_mc_ctrl
  import ex_mc_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  ex_mc_ctrl_if.slave        bus,
  output logic [STATE_W-1:0] dbg_state
);

  logic [STATE_W-1:0] state;
  logic [DWORD_W-1:0] temp;
  logic [DWORD_W-1:0] div_result_q;
  logic [DWORD_W-1:0] acc;
  logic               mem_free;
  logic               unused_stall;

  assign mem_free     = (bus.stall[STALL_MEM] == NO_STOP);
  assign unused_stall = ^{bus.stall[STALL_W-1], bus.stall[STALL_EX:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      temp         <= {ZERO_WORD, ZERO_WORD};
      div_result_q <= {ZERO_WORD, ZERO_WORD};
    end else if (bus.annul_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.op_madd_i) begin
            temp  <= bus.mul_i;
            state <= MADD2;
          end else if (bus.op_div_i) begin
            state <= DIV_BUSY;
          end
        end
        MADD2: begin
          if (mem_free) state <= IDLE;
        end
        DIV_BUSY: begin
          if (bus.div_ready_i) begin
            div_result_q <= bus.div_result_i;
            state        <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (mem_free) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Accumulation uses the live forwarded HI/LO so a late HI/LO writer is seen.
  assign acc = bus.op_sub_i ? (bus.hilo_i - temp) : (bus.hilo_i + temp);

  assign bus.stallreq_o    = ((state == IDLE) && (bus.op_madd_i || bus.op_div_i)
                              && !bus.annul_i) || (state == DIV_BUSY);
  assign bus.div_start_o   = (state == DIV_BUSY);
  assign bus.div_annul_o   = bus.annul_i && (state == DIV_BUSY);
  assign bus.madd_valid_o  = (state == MADD2);
  assign bus.madd_result_o = (state == MADD2) ? acc : bus.hilo_i;
  assign bus.div_valid_o   = (state == DIV_DONE);
  assign bus.div_result_o  = div_result_q;
  assign dbg_state         = state;

endmodule

// File: tb/tb_ex_mc_ctrl.sv
// Directed bench for ex_mc_ctrl: madd/msub, stall hold, divider sequencing,
// annul and reset behaviour, checked against hand-computed values.
module tb_ex_mc_ctrl;
  import ex_mc_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [STATE_W-1:0] dbg_state;
  int                 n_cmp = 0;
  int                 n_err = 0;
  int                 stall_cnt;

  ex_mc_ctrl_if bus ();

  ex_mc_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.stall        = '0;
    bus.annul_i      = 1'b0;
    bus.op_madd_i    = 1'b0;
    bus.op_sub_i     = 1'b0;
    bus.mul_i        = '0;
    bus.hilo_i       = 64'h0000_0000_0000_1234;
    bus.op_div_i     = 1'b0;
    bus.div_ready_i  = 1'b0;
    bus.div_result_i = '0;

    // reset state
    tick(); tick();
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    chk("rst_stallreq", 64'(bus.stallreq_o), 64'd0);
    chk("rst_div_start", 64'(bus.div_start_o), 64'd0);
    chk("rst_madd_valid", 64'(bus.madd_valid_o), 64'd0);
    chk("rst_div_valid", 64'(bus.div_valid_o), 64'd0);
    chk("rst_div_result", bus.div_result_o, 64'd0);
    chk("rst_madd_follow", bus.madd_result_o, 64'h0000_0000_0000_1234);
    rst = 1'b0;
    tick();

    // madd: 0x1_0000_0005 + 3
    bus.hilo_i    = 64'h0000_0001_0000_0005;
    bus.mul_i     = 64'h3;
    bus.op_madd_i = 1'b1;
    #1;
    chk("madd_stallreq", 64'(bus.stallreq_o), 64'd1);
    tick();
    bus.mul_i = 64'h99;
    #1;
    chk("madd_valid", 64'(bus.madd_valid_o), 64'd1);
    chk("madd_result", bus.madd_result_o, 64'h0000_0001_0000_0008);
    chk("madd2_stallreq", 64'(bus.stallreq_o), 64'd0);
    bus.op_madd_i = 1'b0;
    tick();
    chk("madd_back_idle", 64'(dbg_state), 64'(IDLE));
    chk("madd_valid_drop", 64'(bus.madd_valid_o), 64'd0);

    // msub wrap: 0 - 1
    bus.hilo_i    = 64'h0;
    bus.mul_i     = 64'h1;
    bus.op_madd_i = 1'b1;
    bus.op_sub_i  = 1'b1;
    tick();
    chk("msub_result", bus.madd_result_o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("msub_valid", 64'(bus.madd_valid_o), 64'd1);
    bus.op_madd_i = 1'b0;
    bus.op_sub_i  = 1'b0;
    tick();

    // stall[4] hold in MADD2 for 3 cycles: valid held 4 cycles, no re-capture
    bus.hilo_i    = 64'h10;
    bus.mul_i     = 64'h5;
    bus.op_madd_i = 1'b1;
    tick();
    bus.mul_i = 64'h77;
    for (int i = 0; i < 4; i++) begin
      bus.stall = (i < 3) ? 6'b011000 : 6'b000000;
      #1;
      chk($sformatf("hold_valid_%0d", i), 64'(bus.madd_valid_o), 64'd1);
      chk($sformatf("hold_result_%0d", i), bus.madd_result_o, 64'h15);
      if (i == 3) bus.op_madd_i = 1'b0;
      tick();
    end
    chk("hold_release_idle", 64'(dbg_state), 64'(IDLE));
    chk("hold_release_valid", 64'(bus.madd_valid_o), 64'd0);

    // divide: ready on the 33rd busy cycle, stallreq high 34 cycles
    bus.op_div_i = 1'b1;
    stall_cnt = 0;
    #1;
    if (bus.stallreq_o) stall_cnt++;
    tick();
    for (int k = 1; k <= 33; k++) begin
      bus.div_ready_i  = (k == 33);
      bus.div_result_i = (k == 33) ? 64'h0000_0001_0000_0003 : 64'(k) * 64'h1111;
      #1;
      if (bus.stallreq_o) stall_cnt++;
      if (k == 1 || k == 33) chk($sformatf("div_start_%0d", k), 64'(bus.div_start_o), 64'd1);
      tick();
    end
    bus.div_ready_i = 1'b0;
    #1;
    chk("div_stall_cycles", 64'(stall_cnt), 64'd34);
    chk("div_valid", 64'(bus.div_valid_o), 64'd1);
    chk("div_result", bus.div_result_o, 64'h0000_0001_0000_0003);
    chk("div_done_stallreq", 64'(bus.stallreq_o), 64'd0);
    chk("div_done_start", 64'(bus.div_start_o), 64'd0);
    // late ready in DIV_DONE under stall[4] must be ignored
    bus.stall        = 6'b011000;
    bus.div_ready_i  = 1'b1;
    bus.div_result_i = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    bus.div_ready_i = 1'b0;
    chk("div_done_hold", 64'(dbg_state), 64'(DIV_DONE));
    chk("div_done_result", bus.div_result_o, 64'h0000_0001_0000_0003);
    bus.stall    = '0;
    bus.op_div_i = 1'b0;
    tick();
    chk("div_back_idle", 64'(dbg_state), 64'(IDLE));

    // annul in DIV_BUSY cycle 10
    bus.op_div_i = 1'b1;
    tick();
    for (int k = 1; k <= 10; k++) begin
      bus.annul_i = (k == 10);
      #1;
      if (k == 9 || k == 10)
        chk($sformatf("annul_div_annul_%0d", k), 64'(bus.div_annul_o), 64'(k == 10));
      tick();
    end
    bus.annul_i  = 1'b0;
    bus.op_div_i = 1'b0;
    #1;
    chk("annul_idle", 64'(dbg_state), 64'(IDLE));
    chk("annul_div_start", 64'(bus.div_start_o), 64'd0);
    chk("annul_div_valid", 64'(bus.div_valid_o), 64'd0);
    bus.div_ready_i  = 1'b1;
    bus.div_result_i = 64'hAAAA_5555_AAAA_5555;
    tick();
    bus.div_ready_i = 1'b0;
    chk("idle_ready_ignored_state", 64'(dbg_state), 64'(IDLE));
    chk("idle_ready_ignored_res", bus.div_result_o, 64'h0000_0001_0000_0003);

    // reset mid DIV_BUSY: no abort, start drops next cycle
    bus.op_div_i = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_busy_annul", 64'(bus.div_annul_o), 64'd0);
    tick();
    bus.op_div_i = 1'b0;
    #1;
    chk("rst_busy_start", 64'(bus.div_start_o), 64'd0);
    chk("rst_busy_state", 64'(dbg_state), 64'(IDLE));
    chk("rst_busy_result", bus.div_result_o, 64'd0);
    rst = 1'b0;
    tick();

    // madd wins over div; annul suppresses stallreq in IDLE
    bus.op_madd_i = 1'b1;
    bus.op_div_i  = 1'b1;
    bus.annul_i   = 1'b1;
    #1;
    chk("annul_idle_stallreq", 64'(bus.stallreq_o), 64'd0);
    bus.annul_i = 1'b0;
    tick();
    chk("prio_madd", 64'(dbg_state), 64'(MADD2));
    bus.op_madd_i = 1'b0;
    bus.op_div_i  = 1'b0;
    tick();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
